packet_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the packet classifier's single Avalon-ST sink between NUM_INPUTS upstream Avalon-ST sources.
- Sits directly in front of the classifier.
- Grants one input per whole packet (sop to eop), forwards it combinationally, and tags the output with the granted input index.
- Drains and counts out-of-packet beats so an errant source cannot stall the classifier.

---
 rtl/packet_arbiter.sv | 171 +++++++++++++++++
 tb/tb_packet_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_arbiter.sv
// ---------------------------------------------------------------------------
// packet_arbiter
//
// Packet-level round-robin arbiter that shares the packet classifier's single
// Avalon-ST sink between NUM_INPUTS upstream Avalon-ST sources. One input is
// granted for a whole packet (sop through eop). Its beats are forwarded
// combinationally, and each beat is tagged with the granted input index.
// While idle, beats that arrive without a packet context (valid but not sop)
// are drained and counted, so an errant source cannot stall the classifier.
//
// Ports:
//   clk_i, arst_i          clock, asynchronous active-high reset
//   arb_en_i               1 = new grants allowed; 0 = finish packet, then idle
//   sink_*_i / sink_ready_o  NUM_INPUTS packed Avalon-ST sink interfaces
//                          (input i occupies slice i of each packed bus)
//   src_*_o / src_ready_i  single Avalon-ST source towards the classifier
//   src_channel_o          index of the granted input
//   busy_o                 high while a packet grant is active
//   drop_cnt_o             saturating count of drained out-of-packet beats
// ---------------------------------------------------------------------------
module packet_arbiter #(
    parameter int AST_DWIDTH  = 64,
    parameter int NUM_INPUTS  = 2,
    parameter int IDX_WIDTH   = $clog2(NUM_INPUTS),
    parameter int EMPTY_WIDTH = $clog2(AST_DWIDTH/8),
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic                              arb_en_i,
    input  logic [NUM_INPUTS*AST_DWIDTH-1:0]  sink_data_i,
    input  logic [NUM_INPUTS-1:0]             sink_valid_i,
    input  logic [NUM_INPUTS-1:0]             sink_startofpacket_i,
    input  logic [NUM_INPUTS-1:0]             sink_endofpacket_i,
    input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] sink_empty_i,
    output logic [NUM_INPUTS-1:0]             sink_ready_o,
    output logic [AST_DWIDTH-1:0]             src_data_o,
    output logic                              src_valid_o,
    output logic                              src_startofpacket_o,
    output logic                              src_endofpacket_o,
    output logic [EMPTY_WIDTH-1:0]            src_empty_o,
    output logic [IDX_WIDTH-1:0]              src_channel_o,
    input  logic                              src_ready_i,
    output logic                              busy_o,
    output logic [CNT_WIDTH-1:0]              drop_cnt_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [IDX_WIDTH-1:0]   r_grant;
    logic [IDX_WIDTH-1:0]   w_nextGrant;
    logic [IDX_WIDTH-1:0]   r_lastGrant;
    logic [IDX_WIDTH-1:0]   w_nextLastGrant;
    logic [CNT_WIDTH-1:0]   r_dropCnt;
    logic [CNT_WIDTH-1:0]   w_nextDropCnt;

    logic [NUM_INPUTS-1:0]  w_req;
    logic [NUM_INPUTS-1:0]  w_drain;
    logic [IDX_WIDTH-1:0]   w_cand [NUM_INPUTS];
    logic [IDX_WIDTH-1:0]   w_rrGrant;
    logic                   w_reqAny;
    logic [CNT_WIDTH:0]     w_drainCount;
    logic [CNT_WIDTH:0]     w_dropSum;
    logic                   w_grantEop;

    // A packet request is a valid beat carrying sop. Any other valid beat seen
    // while idle has no packet context and is drained instead of forwarded.
    assign w_req   = sink_valid_i & sink_startofpacket_i;
    assign w_drain = (r_state == ST_IDLE) ? (sink_valid_i & ~sink_startofpacket_i)
                                          : '0;

    // Candidate search order starts just after the last granted input and
    // wraps, so the most recently served input has the lowest priority.
    always_comb begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_cand[k] = IDX_WIDTH'((int'(r_lastGrant) + k + 1) % NUM_INPUTS);
        end
    end

    // Walk the candidates from lowest priority to highest so the highest
    // priority requester is the last one written and therefore wins.
    always_comb begin
        w_rrGrant = r_grant;
        w_reqAny  = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (w_req[w_cand[k]]) begin
                w_rrGrant = w_cand[k];
                w_reqAny  = 1'b1;
            end
        end
    end

    // Number of inputs drained this cycle, added to the drop counter with one
    // extra bit of headroom so saturation can be detected from the carry.
    always_comb begin
        w_drainCount = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_drainCount = w_drainCount + {{CNT_WIDTH{1'b0}}, w_drain[i]};
        end
        w_dropSum     = {1'b0, r_dropCnt} + w_drainCount;
        w_nextDropCnt = w_dropSum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                             : w_dropSum[CNT_WIDTH-1:0];
    end

    // The data fields always come from the input held in the grant register,
    // even while idle; only valid is gated, so the classifier sees no beat.
    assign src_data_o          = sink_data_i[r_grant*AST_DWIDTH +: AST_DWIDTH];
    assign src_startofpacket_o = sink_startofpacket_i[r_grant];
    assign src_endofpacket_o   = sink_endofpacket_i[r_grant];
    assign src_empty_o         = sink_empty_i[r_grant*EMPTY_WIDTH +: EMPTY_WIDTH];
    assign src_channel_o       = r_grant;
    assign drop_cnt_o          = r_dropCnt;

    // The packet ends on the transfer of an eop beat from the granted input.
    // A sop seen mid-packet is just data and does not end or split the grant.
    assign w_grantEop = sink_valid_i[r_grant] & src_ready_i & sink_endofpacket_i[r_grant];

    // Next-state and handshake logic. Ready towards the granted input is a
    // straight copy of the classifier's ready; valid never depends on ready.
    always_comb begin
        w_nextState     = r_state;
        w_nextGrant     = r_grant;
        w_nextLastGrant = r_lastGrant;
        sink_ready_o    = '0;
        src_valid_o     = 1'b0;
        busy_o          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                sink_ready_o = w_drain;
                if (arb_en_i && w_reqAny) begin
                    w_nextGrant = w_rrGrant;
                    w_nextState = ST_GRANT;
                end
            end
            ST_GRANT: begin
                src_valid_o           = sink_valid_i[r_grant];
                sink_ready_o[r_grant] = src_ready_i;
                busy_o                = 1'b1;
                if (w_grantEop) begin
                    w_nextLastGrant = r_grant;
                    w_nextState     = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State registers. The last-grant reset value makes input 0 the first
    // input served after reset; a reset mid-packet simply abandons it.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_lastGrant <= IDX_WIDTH'(NUM_INPUTS - 1);
            r_dropCnt   <= '0;
        end else begin
            r_state     <= w_nextState;
            r_grant     <= w_nextGrant;
            r_lastGrant <= w_nextLastGrant;
            r_dropCnt   <= w_nextDropCnt;
        end
    end

endmodule

// File: tb/tb_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_packet_arbiter
//
// Directed bench for packet_arbiter with two inputs. Each input is modelled
// as a queue of beats whose head is presented and popped when accepted.
// Expected output beats are pushed into a scoreboard queue, in the order the
// round-robin arbiter should grant them, when the packets are queued. They
// are popped and compared whenever the DUT transfers a beat to the classifier.
// ---------------------------------------------------------------------------
module tb_packet_arbiter;

    localparam int DW = 64;
    localparam int NI = 2;
    localparam int IW = 1;
    localparam int EW = 3;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    typedef struct packed {
        beat_t         beat;
        logic [IW-1:0] channel;
    } exp_t;

    logic               clk;
    logic               arst;
    logic               arbEn;
    logic [NI*DW-1:0]   sinkData;
    logic [NI-1:0]      sinkValid;
    logic [NI-1:0]      sinkSop;
    logic [NI-1:0]      sinkEop;
    logic [NI*EW-1:0]   sinkEmpty;
    logic [NI-1:0]      sinkReady;
    logic [DW-1:0]      srcData;
    logic               srcValid;
    logic               srcSop;
    logic               srcEop;
    logic [EW-1:0]      srcEmpty;
    logic [IW-1:0]      srcChannel;
    logic               srcReady;
    logic               busy;
    logic [CW-1:0]      dropCnt;

    beat_t srcQ0[$];
    beat_t srcQ1[$];
    exp_t  expQ[$];

    int    compareCount = 0;
    int    mismatchCount = 0;
    int    cycleNum = 0;
    int    lastEopCycle = 0;
    bit    haveEop = 0;
    bit    checkGap = 0;
    logic  [NI-1:0] obsSinkReady;
    logic  obsValid;
    logic  readyPat [4];

    packet_arbiter #(
        .AST_DWIDTH (DW),
        .NUM_INPUTS (NI),
        .IDX_WIDTH  (IW),
        .EMPTY_WIDTH(EW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i               (clk),
        .arst_i              (arst),
        .arb_en_i            (arbEn),
        .sink_data_i         (sinkData),
        .sink_valid_i        (sinkValid),
        .sink_startofpacket_i(sinkSop),
        .sink_endofpacket_i  (sinkEop),
        .sink_empty_i        (sinkEmpty),
        .sink_ready_o        (sinkReady),
        .src_data_o          (srcData),
        .src_valid_o         (srcValid),
        .src_startofpacket_o (srcSop),
        .src_endofpacket_o   (srcEop),
        .src_empty_o         (srcEmpty),
        .src_channel_o       (srcChannel),
        .src_ready_i         (srcReady),
        .busy_o              (busy),
        .drop_cnt_o          (dropCnt)
    );

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and counts and reports it when it differs.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Queue a packet on one input; packets starting with sop are also pushed to
    // the scoreboard tagged with the channel they should appear on.
    task automatic queuePacket(input int src, input int nBeats,
                               input logic [DW-1:0] base, input bit withSop);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < nBeats; k++) begin
            b.data  = base * DW'(k + 1);
            b.sop   = withSop && (k == 0);
            b.eop   = (k == nBeats - 1);
            b.empty = b.eop ? EW'(nBeats) : '0;
            if (src == 0) srcQ0.push_back(b);
            else          srcQ1.push_back(b);
            if (withSop) begin
                e.beat    = b;
                e.channel = IW'(src);
                expQ.push_back(e);
            end
        end
    endtask

    // Present the head beat of each source queue, or nothing when empty.
    task automatic driveHeads();
        sinkValid = '0;
        sinkSop   = '0;
        sinkEop   = '0;
        sinkEmpty = '0;
        sinkData  = '0;
        if (srcQ0.size() > 0) begin
            sinkValid[0]     = 1'b1;
            sinkData[63:0]   = srcQ0[0].data;
            sinkSop[0]       = srcQ0[0].sop;
            sinkEop[0]       = srcQ0[0].eop;
            sinkEmpty[2:0]   = srcQ0[0].empty;
        end
        if (srcQ1.size() > 0) begin
            sinkValid[1]     = 1'b1;
            sinkData[127:64] = srcQ1[0].data;
            sinkSop[1]       = srcQ1[0].sop;
            sinkEop[1]       = srcQ1[0].eop;
            sinkEmpty[5:3]   = srcQ1[0].empty;
        end
    endtask

    // Scoreboard side: compare a transferred beat against the oldest expected.
    task automatic monitorBeat();
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpectedBeat", 128'(expQ.size()), 128'(1));
        end else begin
            e = expQ.pop_front();
            checkOutput("beat", {srcData, srcSop, srcEop, srcEmpty, srcChannel}, e);
        end
        if (srcSop && checkGap && haveEop)
            checkOutput("gapCycles", 128'(cycleNum - lastEopCycle), 128'(2));
        if (srcEop) begin
            lastEopCycle = cycleNum;
            haveEop      = 1'b1;
        end
    endtask

    // Run n clock cycles: drive heads after the edge, sample at the falling
    // edge, and pop whatever each source handed over at the rising edge.
    task automatic applyStimulus(input int n);
        logic acc0;
        logic acc1;
        for (int c = 0; c < n; c++) begin
            driveHeads();
            @(negedge clk);
            obsSinkReady = sinkReady;
            obsValid     = srcValid;
            acc0         = sinkValid[0] & sinkReady[0];
            acc1         = sinkValid[1] & sinkReady[1];
            if (srcValid && srcReady) monitorBeat();
            @(posedge clk);
            #1;
            cycleNum++;
            if (acc0) void'(srcQ0.pop_front());
            if (acc1) void'(srcQ1.pop_front());
        end
    endtask

    // Step until the scoreboard is empty and the arbiter is idle, bounded.
    task automatic runUntilIdle(input int budget);
        int c;
        c = 0;
        while ((expQ.size() != 0 || busy) && c < budget) begin
            applyStimulus(1);
            c++;
        end
        checkOutput("drainTimeout", 128'(expQ.size()), 128'(0));
    endtask

    task automatic doReset();
        arst = 1'b1;
        srcQ0.delete();
        srcQ1.delete();
        expQ.delete();
        applyStimulus(2);
        arst = 1'b0;
        checkOutput("resetState", {srcValid, busy, srcChannel, dropCnt, sinkReady}, 128'(0));
    endtask

    initial begin
        arst      = 1'b1;
        arbEn     = 1'b1;
        srcReady  = 1'b1;
        sinkData  = '0;
        sinkValid = '0;
        sinkSop   = '0;
        sinkEop   = '0;
        sinkEmpty = '0;
        readyPat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        #1;

        // Test 1: single 3-beat packet on input 0.
        doReset();
        queuePacket(0, 3, 64'h1111_1111_1111_1111, 1'b1);
        applyStimulus(1);
        checkOutput("t1IdleValid", obsValid, 0);
        checkOutput("t1BusyAfterArb", busy, 1);
        applyStimulus(1);
        checkOutput("t1FirstBeatValid", obsValid, 1);
        applyStimulus(2);
        checkOutput("t1BusyAfterEop", busy, 0);
        checkOutput("t1AllBeatsOut", 128'(expQ.size()), 128'(0));

        // Test 2: both inputs request continuously; expect 0,1,0,1 with gaps.
        doReset();
        checkGap = 1'b1;
        haveEop  = 1'b0;
        queuePacket(0, 2, 64'h0A0A_0000_0000_0001, 1'b1);
        queuePacket(1, 2, 64'h0B0B_0000_0000_0001, 1'b1);
        queuePacket(0, 2, 64'h0C0C_0000_0000_0001, 1'b1);
        queuePacket(1, 2, 64'h0D0D_0000_0000_0001, 1'b1);
        runUntilIdle(40);
        checkGap = 1'b0;

        // Test 3: four out-of-packet beats on input 1 while idle are drained.
        queuePacket(1, 4, 64'h5A5A_0000_0000_0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("t3SrcValid", obsValid, 0);
            checkOutput("t3DrainReady", obsSinkReady, 2'b10);
        end
        checkOutput("t3DropCnt", dropCnt, 4);
        checkOutput("t3Input1Empty", 128'(srcQ1.size()), 128'(0));

        // Test 4: back-pressure pattern during an input 0 grant.
        queuePacket(0, 4, 64'h0E0E_0000_0000_0001, 1'b1);
        queuePacket(1, 2, 64'h0F0F_0000_0000_0001, 1'b1);
        applyStimulus(1);
        for (int i = 0; i < 4; i++) begin
            srcReady = readyPat[i];
            applyStimulus(1);
            checkOutput("t4Ready0", obsSinkReady[0], readyPat[i]);
            checkOutput("t4Ready1", obsSinkReady[1], 0);
        end
        srcReady = 1'b1;
        runUntilIdle(40);

        // Test 5: grants disabled mid-packet on input 1.
        queuePacket(1, 3, 64'h3131_0000_0000_0001, 1'b1);
        applyStimulus(2);
        arbEn = 1'b0;
        queuePacket(0, 1, 64'h7777_0000_0000_0001, 1'b1);
        applyStimulus(2);
        checkOutput("t5BusyAfterEop", busy, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("t5HeldValid", obsValid, 0);
            checkOutput("t5HeldReady0", obsSinkReady[0], 0);
            checkOutput("t5HeldBusy", busy, 0);
        end
        arbEn = 1'b1;
        applyStimulus(1);
        checkOutput("t5GrantNextCycle", busy, 1);
        runUntilIdle(20);

        // Test 6: asynchronous reset during the second beat of a packet.
        queuePacket(0, 4, 64'h6161_0000_0000_0001, 1'b1);
        applyStimulus(2);
        driveHeads();
        #1;
        checkOutput("t6MidPacketValid", srcValid, 1);
        #1;
        arst = 1'b1;
        #1;
        checkOutput("t6ResetValid", srcValid, 0);
        checkOutput("t6ResetBusy", busy, 0);
        srcQ0.delete();
        srcQ1.delete();
        expQ.delete();
        sinkValid = '0;
        applyStimulus(2);
        arst = 1'b0;
        checkOutput("t6AfterRelease", {srcValid, busy, srcChannel, dropCnt}, 128'(0));
        queuePacket(0, 1, 64'h9191_0000_0000_0001, 1'b1);
        queuePacket(1, 1, 64'h8181_0000_0000_0001, 1'b1);
        runUntilIdle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
